alu_mc: RTL and testbench
=========================

ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; legal values 8..64, even.
REQ-002 Parameter SHW, default $clog2(XLEN), shift-amount width taken from SrcB[SHW-1:0].
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 InValid  input  1  request present on SrcA/SrcB/ALUControl.
REQ-006 InReady  output  1  block can accept a request this cycle.
REQ-007 SrcA  input  XLEN  operand A.
REQ-008 SrcB  input  XLEN  operand B.
REQ-009 ALUControl  input  4  operation selector.
REQ-010 OutValid  output  1  ALUResult/Zero valid.
REQ-011 OutReady  input  1  consumer takes result this cycle.
REQ-012 ALUResult  output  XLEN  registered result.
REQ-013 Zero  output  1  registered; 1 iff ALUResult == 0.

Function
REQ-014 Encoding SHALL be: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLL, 0110 SRL, 0111 SRA, 1000 SLT (signed, result 0/1), 1001 SLTU, 1010 MUL (low XLEN bits), 1011 MULHU (high XLEN bits, unsigned), 1100 DIVU, 1101 REMU; 1110/1111 yield result 0.
REQ-015 Arithmetic SHALL be modulo 2^XLEN; no overflow flag; shifts use SrcB[SHW-1:0] only.
REQ-016 FSM states SHALL be IDLE, BUSY, DONE.
REQ-017 InReady SHALL equal (state == IDLE); accept = InValid && InReady at a rising edge; operands and op captured at accept.
REQ-018 Single-cycle ops (0000-1001, 1110, 1111) and DIVU/REMU with SrcB==0: IDLE -> DONE at accept; OutValid high the cycle after accept (latency 1).
REQ-019 MUL/MULHU/DIVU/REMU (divisor nonzero): IDLE -> BUSY at accept; iterative shift-add multiply / restoring divide, one bit per cycle; BUSY -> DONE after exactly XLEN cycles in BUSY; OutValid high XLEN+1 cycles after accept.
REQ-020 Divide by zero: DIVU result all ones; REMU result = SrcA.
REQ-021 DONE: OutValid=1, ALUResult/Zero stable; DONE -> IDLE at edge where OutReady=1; OutValid deasserts next cycle.
REQ-022 No request accepted while BUSY or DONE; InValid ignored then (InReady=0); a new accept is possible no earlier than the cycle after DONE -> IDLE.
REQ-023 OutReady while not DONE SHALL have no effect.
REQ-024 ALUResult/Zero SHALL change only on entry to DONE; held otherwise.
REQ-025 Operand/op changes after accept SHALL NOT affect the in-flight result.

Reset
REQ-026 rst_n=0 SHALL immediately force state IDLE, OutValid=0, ALUResult=0, Zero=1, iteration counter and datapath registers to 0, independent of clk.
REQ-027 Reset mid-BUSY or in DONE SHALL abort the operation; no result is produced; InReady=1 from first edge-free cycle after rst_n rises.
REQ-028 Post-reset, first accept possible on first rising edge with rst_n=1.

Verification
REQ-029 XLEN=32, ADD 0xFFFFFFFF + 0x1, OutReady=1 -> OutValid one cycle after accept, ALUResult=0x0, Zero=1; InReady back to 1 next cycle.
REQ-030 SRA 0x80000000 by SrcB=0x24 (amount 4) -> 0xF8000000; SLT 0xFFFFFFFF,0x1 -> 1; SLTU same operands -> 0.
REQ-031 MUL 0x00010000*0x00010000 -> 0x00000000, Zero=1; MULHU same -> 0x00000001; OutValid exactly 33 cycles after accept; InReady=0 throughout.
REQ-032 DIVU 100/7 -> 14, REMU 100/7 -> 2 (latency 33); DIVU x/0 -> 0xFFFFFFFF, REMU 0x1234/0 -> 0x1234 (latency 1).
REQ-033 Backpressure: result in DONE with OutReady=0 for 5 cycles, InValid=1 with new operands -> ALUResult held, no accept, InReady=0; OutReady=1 -> DONE->IDLE, next request accepted following cycle.
REQ-034 Assert rst_n=0 at BUSY cycle 10 of a DIVU -> OutValid=0, ALUResult=0, Zero=1 asynchronously; after release, ADD 2+3 -> 5 with latency 1.

Source files
------------

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/shift/compare ops, iterative shift-add multiply
// and restoring divide (one bit per cycle), with a valid/ready handshake on both sides.
module alu_mc #(
   parameter int XLEN = 32,
   parameter int SHW  = $clog2(XLEN)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            InValid,
   output logic            InReady,
   input  logic [XLEN-1:0] SrcA,
   input  logic [XLEN-1:0] SrcB,
   input  logic [3:0]      ALUControl,
   output logic            OutValid,
   input  logic            OutReady,
   output logic [XLEN-1:0] ALUResult,
   output logic            Zero
);

   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

   localparam int            CW       = $clog2(XLEN + 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(XLEN - 1);

   localparam logic [3:0] OP_ADD  = 4'b0000, OP_SUB   = 4'b0001, OP_AND  = 4'b0010,
                          OP_OR   = 4'b0011, OP_XOR   = 4'b0100, OP_SLL  = 4'b0101,
                          OP_SRL  = 4'b0110, OP_SRA   = 4'b0111, OP_SLT  = 4'b1000,
                          OP_SLTU = 4'b1001, OP_MUL   = 4'b1010, OP_MULHU = 4'b1011,
                          OP_DIVU = 4'b1100, OP_REMU  = 4'b1101;

   state_t            state_r, state_nxt_s;
   logic [3:0]        op_r;
   logic [CW-1:0]     cnt_r;
   logic [XLEN-1:0]   hi_r, lo_r, b_r;
   logic [XLEN-1:0]   result_r;
   logic              zero_r;
   logic              out_valid_r;

   logic [SHW-1:0]    sh_s;
   logic [XLEN-1:0]   quick_s;
   logic              start_s, iter_op_s, is_mul_s, last_s;
   logic [XLEN:0]     mul_sum_s, div_shift_s, div_diff_s;
   logic [XLEN-1:0]   hi_nxt_s, lo_nxt_s, fin_s;

   assign sh_s      = SrcB[SHW-1:0];
   assign start_s   = InValid && (state_r == IDLE);
   assign last_s    = (cnt_r == LAST_CNT);
   assign InReady   = (state_r == IDLE);
   assign OutValid  = out_valid_r;
   assign ALUResult = result_r;
   assign Zero      = zero_r;

   // Result of every op that completes at accept (including divide by zero).
   always_comb begin
      quick_s = {XLEN{1'b0}};
      case (ALUControl)
         OP_ADD:  quick_s = SrcA + SrcB;
         OP_SUB:  quick_s = SrcA - SrcB;
         OP_AND:  quick_s = SrcA & SrcB;
         OP_OR:   quick_s = SrcA | SrcB;
         OP_XOR:  quick_s = SrcA ^ SrcB;
         OP_SLL:  quick_s = SrcA << sh_s;
         OP_SRL:  quick_s = SrcA >> sh_s;
         OP_SRA:  quick_s = $unsigned($signed(SrcA) >>> sh_s);
         OP_SLT:  quick_s = {{(XLEN-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
         OP_SLTU: quick_s = {{(XLEN-1){1'b0}}, (SrcA < SrcB)};
         OP_DIVU: quick_s = {XLEN{1'b1}};
         OP_REMU: quick_s = SrcA;
         default: quick_s = {XLEN{1'b0}};
      endcase
   end

   // Decide whether the presented op needs the iterative datapath.
   always_comb begin
      iter_op_s = 1'b0;
      case (ALUControl)
         OP_MUL, OP_MULHU: iter_op_s = 1'b1;
         OP_DIVU, OP_REMU: iter_op_s = (SrcB != {XLEN{1'b0}});
         default:          iter_op_s = 1'b0;
      endcase
   end

   // One iteration step: {hi,lo} is the product (multiplier in lo) or remainder/quotient.
   always_comb begin
      is_mul_s    = (op_r == OP_MUL) || (op_r == OP_MULHU);
      mul_sum_s   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, b_r} : {(XLEN+1){1'b0}});
      div_shift_s = {hi_r, lo_r[XLEN-1]};
      div_diff_s  = div_shift_s - {1'b0, b_r};
      if (is_mul_s) begin
         hi_nxt_s = mul_sum_s[XLEN:1];
         lo_nxt_s = {mul_sum_s[0], lo_r[XLEN-1:1]};
      end else if (!div_diff_s[XLEN]) begin
         hi_nxt_s = div_diff_s[XLEN-1:0];
         lo_nxt_s = {lo_r[XLEN-2:0], 1'b1};
      end else begin
         hi_nxt_s = div_shift_s[XLEN-1:0];
         lo_nxt_s = {lo_r[XLEN-2:0], 1'b0};
      end
      case (op_r)
         OP_MUL:   fin_s = lo_nxt_s;
         OP_MULHU: fin_s = hi_nxt_s;
         OP_DIVU:  fin_s = lo_nxt_s;
         OP_REMU:  fin_s = hi_nxt_s;
         default:  fin_s = {XLEN{1'b0}};
      endcase
   end

   // Next-state logic for the IDLE/BUSY/DONE control FSM.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (start_s) state_nxt_s = iter_op_s ? BUSY : DONE;
            else         state_nxt_s = IDLE;
         end
         BUSY: begin
            if (last_s) state_nxt_s = DONE;
            else        state_nxt_s = BUSY;
         end
         DONE: begin
            if (OutReady) state_nxt_s = IDLE;
            else          state_nxt_s = DONE;
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // State register; OutValid tracks entry into DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         out_valid_r <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         out_valid_r <= (state_nxt_s == DONE);
      end
   end

   // Operand capture, iteration and result registers (result only written on DONE entry).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_r     <= 4'b0000;
         cnt_r    <= {CW{1'b0}};
         hi_r     <= {XLEN{1'b0}};
         lo_r     <= {XLEN{1'b0}};
         b_r      <= {XLEN{1'b0}};
         result_r <= {XLEN{1'b0}};
         zero_r   <= 1'b1;
      end else if (start_s) begin
         op_r  <= ALUControl;
         cnt_r <= {CW{1'b0}};
         hi_r  <= {XLEN{1'b0}};
         lo_r  <= SrcA;
         b_r   <= SrcB;
         if (!iter_op_s) begin
            result_r <= quick_s;
            zero_r   <= (quick_s == {XLEN{1'b0}});
         end
      end else if (state_r == BUSY) begin
         hi_r  <= hi_nxt_s;
         lo_r  <= lo_nxt_s;
         cnt_r <= cnt_r + CW'(1);
         if (last_s) begin
            result_r <= fin_s;
            zero_r   <= (fin_s == {XLEN{1'b0}});
         end
      end
   end

endmodule

// File: tb/tb_alu_mc.sv
// Directed self-checking bench for alu_mc (XLEN=32): hand-computed results,
// latency, handshake/backpressure and asynchronous reset behaviour.
module tb_alu_mc;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        InValid;
   logic        InReady;
   logic [31:0] SrcA;
   logic [31:0] SrcB;
   logic [3:0]  ALUControl;
   logic        OutValid;
   logic        OutReady;
   logic [31:0] ALUResult;
   logic        Zero;

   int checks   = 0;
   int failures = 0;

   alu_mc #(.XLEN(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .InValid(InValid), .InReady(InReady),
      .SrcA(SrcA), .SrcB(SrcB), .ALUControl(ALUControl),
      .OutValid(OutValid), .OutReady(OutReady),
      .ALUResult(ALUResult), .Zero(Zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Issue one request from the sampling phase, wait for the result, check it, then drain.
   task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp,
                         input int exp_lat, input logic rdy_while_busy);
      int   lat;
      logic leak;
      InValid    = 1'b1;
      ALUControl = op;
      SrcA       = a;
      SrcB       = b;
      OutReady   = rdy_while_busy;
      check({tag, "_inready_idle"}, 32'(InReady), 32'd1);
      @(posedge clk); #1;
      // Keep a bogus request pending and scramble operands; neither may disturb the result.
      ALUControl = 4'b0000;
      SrcA       = 32'hDEAD_BEEF;
      SrcB       = 32'h0BAD_F00D;
      lat  = 1;
      leak = 1'b0;
      while (OutValid !== 1'b1 && lat < 200) begin
         if (InReady !== 1'b0) leak = 1'b1;
         @(posedge clk); #1;
         lat++;
      end
      check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      check({tag, "_result"}, ALUResult, exp);
      check({tag, "_zero"}, 32'(Zero), 32'(exp == 32'd0));
      check({tag, "_inready_busy"}, 32'(leak | InReady), 32'd0);
      InValid  = 1'b0;
      OutReady = 1'b1;
      @(posedge clk); #1;
      OutReady = 1'b0;
      check({tag, "_drain"}, {30'd0, OutValid, InReady}, 32'd1);
   endtask

   initial begin
      rst_n      = 1'b0;
      InValid    = 1'b0;
      OutReady   = 1'b0;
      SrcA       = 32'd0;
      SrcB       = 32'd0;
      ALUControl = 4'b0000;
      #12;
      check("reset_outvalid", 32'(OutValid), 32'd0);
      check("reset_result", ALUResult, 32'd0);
      check("reset_zero", 32'(Zero), 32'd1);
      check("reset_inready", 32'(InReady), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;

      run_op("add_wrap", 4'b0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1, 1'b1);
      run_op("sub",      4'b0001, 32'd5,         32'd7,         32'hFFFF_FFFE, 1, 1'b0);
      run_op("xor",      4'b0100, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0, 1, 1'b0);
      run_op("sll_amt",  4'b0101, 32'h0000_0001, 32'h0000_0021, 32'h0000_0002, 1, 1'b0);
      run_op("srl",      4'b0110, 32'h8000_0000, 32'd31,        32'h0000_0001, 1, 1'b0);
      run_op("sra",      4'b0111, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 1, 1'b0);
      run_op("slt",      4'b1000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1, 1'b0);
      run_op("sltu",     4'b1001, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1, 1'b0);
      run_op("op1110",   4'b1110, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 1, 1'b0);
      run_op("mul_lo",   4'b1010, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 33, 1'b1);
      run_op("mulhu",    4'b1011, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 33, 1'b0);
      run_op("mul_max",  4'b1010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33, 1'b0);
      run_op("mulhu_mx", 4'b1011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 1'b0);
      run_op("mul_by0",  4'b1010, 32'h0000_1234, 32'h0000_0000, 32'h0000_0000, 33, 1'b0);
      run_op("divu",     4'b1100, 32'd100,       32'd7,         32'd14,        33, 1'b0);
      run_op("remu",     4'b1101, 32'd100,       32'd7,         32'd2,         33, 1'b0);
      run_op("divu_big", 4'b1100, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0FFF_FFFF, 33, 1'b0);
      run_op("divu_z",   4'b1100, 32'd5,         32'd0,         32'hFFFF_FFFF, 1, 1'b0);
      run_op("remu_z",   4'b1101, 32'h0000_1234, 32'd0,         32'h0000_1234, 1, 1'b0);

      // Backpressure: result parked in DONE while a new request waits.
      InValid = 1'b1; ALUControl = 4'b0000; SrcA = 32'd5; SrcB = 32'd6;
      @(posedge clk); #1;
      check("bp_first_valid", 32'(OutValid), 32'd1);
      SrcA = 32'd9; SrcB = 32'd4; ALUControl = 4'b0001;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("bp_hold", {ALUResult[29:0], OutValid, InReady}, {30'd11, 1'b1, 1'b0});
      end
      OutReady = 1'b1;
      @(posedge clk); #1;
      check("bp_release", {30'd0, OutValid, InReady}, 32'd1);
      @(posedge clk); #1;
      OutReady = 1'b0;
      InValid  = 1'b0;
      check("bp_next_result", ALUResult, 32'd5);
      check("bp_next_valid", 32'(OutValid), 32'd1);
      OutReady = 1'b1;
      @(posedge clk); #1;
      OutReady = 1'b0;

      // Reset in the middle of a divide: outputs clear without a clock edge.
      InValid = 1'b1; ALUControl = 4'b1100; SrcA = 32'd1000; SrcB = 32'd3;
      @(posedge clk); #1;
      InValid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
      end
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_async_valid", 32'(OutValid), 32'd0);
      check("rst_async_result", ALUResult, 32'd0);
      check("rst_async_zero", 32'(Zero), 32'd1);
      check("rst_async_ready", 32'(InReady), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("rst_no_result", 32'(OutValid), 32'd0);
      run_op("post_rst_add", 4'b0000, 32'd2, 32'd3, 32'd5, 1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
